// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch
//
// Instruction-fetch stage with a decoupling prefetch queue. A PC generator
// issues single-outstanding requests to a variable-latency instruction memory.
// Returned instructions are queued with their PC+2 in a DEPTH-entry FIFO and
// presented to decode under a valid/stall handshake. A redirect flushes the
// queue and squashes any in-flight response. Fetching stops after a halt
// opcode (5'b00000) until the next redirect, or after an external halt until
// reset.
//
// Optional feature macro: IF_BYPASS_EN
//   When defined, a response arriving while the queue is empty is forwarded
//   combinationally to out_* in the same cycle. It is consumed directly if
//   decode is not stalled, and pushed into the queue otherwise.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   redirect     in   taken branch/jump from execute (highest priority)
//   redirect_pc  in   redirect target
//   halt_in      in   external halt, sticky until rst
//   stall        in   decode cannot accept this cycle
//   imem_req     out  single-cycle request pulse
//   imem_addr    out  request address (0 when no request)
//   imem_done    in   response valid, at least one cycle after the request
//   imem_rdata   in   response instruction
//   out_valid    out  queue head valid
//   out_instr    out  head instruction
//   out_pc2      out  head PC+2
//   out_halt     out  head opcode is 5'b00000
// -----------------------------------------------------------------------------
module if_prefetch #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_in,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_done,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc2,
    output logic              out_halt
);

    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(2);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              outstanding_q, outstanding_d;
    logic              squash_q, squash_d;
    logic              fetch_halt_q, fetch_halt_d;
    logic              ext_halt_q, ext_halt_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc2_mem_q   [DEPTH];

    logic              rsp_valid;
    logic              rsp_keep;
    logic [ADDR_W-1:0] rsp_pc2;
    logic              rsp_halt;
    logic              fifo_empty;
    logic              bypass;
    logic              pop;
    logic              fifo_pop;
    logic              push;
    logic              issue;

    // A done without an outstanding request is ignored entirely.
    assign rsp_valid  = imem_done && outstanding_q;
    // Squashed responses and responses landing in a redirect cycle are dropped.
    assign rsp_keep   = rsp_valid && !squash_q && !redirect;
    assign rsp_pc2    = req_addr_q + PC_STEP;
    assign rsp_halt   = (imem_rdata[DATA_W-1 -: 5] == 5'b00000);
    assign fifo_empty = (count_q == '0);

`ifdef IF_BYPASS_EN
    assign bypass = fifo_empty && rsp_keep;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !fifo_empty || bypass;

    always_comb begin
        out_instr = '0;
        out_pc2   = '0;
        if (bypass) begin
            out_instr = imem_rdata;
            out_pc2   = rsp_pc2;
        end else if (!fifo_empty) begin
            out_instr = instr_mem_q[rd_ptr_q];
            out_pc2   = pc2_mem_q[rd_ptr_q];
        end
    end

    assign out_halt = out_valid && (out_instr[DATA_W-1 -: 5] == 5'b00000);

    // The pop in a redirect cycle is ignored because the queue is flushed.
    assign pop      = out_valid && !stall && !redirect;
    assign fifo_pop = pop && !fifo_empty;
    // A bypassed response is written only when decode stalls on it.
    assign push     = rsp_keep && !(bypass && !stall);

    // With a single outstanding request the credit check reduces to
    // count < DEPTH, which guarantees the eventual push has a free slot.
    assign issue = !rst && !outstanding_q && (count_q < CNT_FULL) &&
                   !fetch_halt_q && !ext_halt_q && !halt_in && !redirect;

    assign imem_req  = issue;
    assign imem_addr = issue ? fetch_pc_q : '0;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_addr_d    = req_addr_q;
        outstanding_d = outstanding_q;
        squash_d      = squash_q;
        fetch_halt_d  = fetch_halt_q;
        ext_halt_d    = ext_halt_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (issue) begin
            fetch_pc_d    = fetch_pc_q + PC_STEP;
            req_addr_d    = fetch_pc_q;
            outstanding_d = 1'b1;
        end

        if (rsp_valid) begin
            outstanding_d = 1'b0;
            if (squash_q) begin
                squash_d = 1'b0;
            end
        end

        if (rsp_keep && rsp_halt) begin
            fetch_halt_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (halt_in) begin
            ext_halt_d = 1'b1;
        end

        if (redirect) begin
            fetch_pc_d   = redirect_pc;
            fetch_halt_d = 1'b0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            if (outstanding_q && !imem_done) begin
                squash_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            req_addr_q    <= '0;
            outstanding_q <= 1'b0;
            squash_q      <= 1'b0;
            fetch_halt_q  <= 1'b0;
            ext_halt_q    <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_addr_q    <= req_addr_d;
            outstanding_q <= outstanding_d;
            squash_q      <= squash_d;
            fetch_halt_q  <= fetch_halt_d;
            ext_halt_q    <= ext_halt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage carries no reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc2_mem_q[wr_ptr_q]   <= rsp_pc2;
        end
    end

endmodule
